pipelined_addsub: RTL

- Parametrised N-bit adder/subtractor with the carry chain pipelined into chunks; the successor to the fixed 4-bit parallel subtractor.
- Adds add/subtract mode, carry/borrow-in, a signed overflow flag, a zero flag, a valid pipeline and a global stall.
- Sits between operand registers and the result bus of the lab ALU datapath.
- Accepts one operation per cycle; each result appears after a fixed latency.

---
 rtl/pipelined_addsub.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Parametrised adder/subtractor whose carry chain is split into STAGES chunks,
// one chunk per registered stage, with a valid bit travelling beside the data.
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES");
  end

  // Flow control: an operand set is taken on a rising edge only when
  // in_valid=1 and stall=0; there is no back-pressure other than stall, which
  // freezes every register (valid bits and outputs included) for that cycle.

  // Register j holds the operands with chunks below j already summed and the
  // carry into chunk j; b is stored already inverted for subtraction.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] bx_q    [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             carry_q [STAGES];
  logic             sub_q   [STAGES];

  logic [CHUNK:0]   part      [STAGES];
  logic [WIDTH-1:0] sum_nxt   [STAGES];
  logic             carry_nxt [STAGES];

  always_comb begin
    for (int j = 0; j < STAGES; j++) begin
      part[j] = {1'b0, a_q[j][j*CHUNK +: CHUNK]}
              + {1'b0, bx_q[j][j*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q[j]};
      sum_nxt[j] = sum_q[j];
      sum_nxt[j][j*CHUNK +: CHUNK] = part[j][CHUNK-1:0];
      carry_nxt[j] = part[j][CHUNK];
    end
  end

  logic [WIDTH-1:0] s_final;
  logic             ovf_final;

  always_comb begin
    s_final   = sum_nxt[LAST];
    ovf_final = (a_q[LAST][WIDTH-1] == bx_q[LAST][WIDTH-1]) &&
                (s_final[WIDTH-1] != a_q[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < STAGES; j++) valid_q[j] <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      for (int j = 1; j < STAGES; j++) valid_q[j] <= valid_q[j-1];
      out_valid <= valid_q[LAST];
      if (valid_q[LAST]) begin
        s    <= s_final;
        cout <= carry_nxt[LAST] ^ sub_q[LAST];
        ovf  <= ovf_final;
        zero <= (s_final == '0);
      end
    end
  end

  // Data registers carry don't-care values under bubbles, so they need no reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        a_q[0]     <= a;
        bx_q[0]    <= sub ? ~b : b;
        carry_q[0] <= cin ^ sub;
        sub_q[0]   <= sub;
        sum_q[0]   <= '0;
      end
      for (int j = 1; j < STAGES; j++) begin
        a_q[j]     <= a_q[j-1];
        bx_q[j]    <= bx_q[j-1];
        sum_q[j]   <= sum_nxt[j-1];
        carry_q[j] <= carry_nxt[j-1];
        sub_q[j]   <= sub_q[j-1];
      end
    end
  end

endmodule
